ai_i2s_rx_frontend: RTL and testbench
=====================================

Name: ai_i2s_rx_frontend

Overview:
Receive-side front end of the I2S RX path, directly upstream of the RX deserializer/FIFO block. It synchronizes external slave-mode SCK/WS/SD into the system clock domain, detects SCK rising edges and WS transitions, and tracks Philips-I2S frame alignment. It drives the downstream block with a single-cycle clk_en strobe and a registered sd bit, asserted only on the data bits of each channel word. It also flags short-word framing errors.

Parameters:
SYNC_STAGES, 2, synchronizer flops on sck_in/ws_in/sd_in (legal >= 2)
CNT_WIDTH, 6, bit-position counter width; counter saturates at 2^CNT_WIDTH-1

Ports:
clk  input  1  system clock; clk frequency >= 4x SCK frequency
rst  input  1  asynchronous reset, active-high
rx_en  input  1  enables reception; low forces IDLE
resolution  input  6  word length in bits; values outside 16..32 are treated as 16
err_clr  input  1  clears frame_err
sck_in  input  1  external I2S bit clock (asynchronous)
ws_in  input  1  external word select (asynchronous)
sd_in  input  1  external serial data (asynchronous)
clk_en  output  1  one-cycle strobe: sd holds a valid data bit
sd  output  1  data bit, valid when clk_en=1
ws  output  1  channel of current bit (0 = left, 1 = right)
frame_start  output  1  pulse coincident with clk_en on the MSB of the left word
word_done  output  1  pulse coincident with clk_en on the LSB of each word
bit_cnt  output  CNT_WIDTH  SCK rising edges since the last WS transition
frame_err  output  1  sticky short-word error flag
locked  output  1  high in ACTIVE

Behaviour:
- Reset (rst=1, async): all outputs 0; state IDLE; counters and sync chains 0.
- Sync: SYNC_STAGES-flop chain per input, plus one history flop on synced sck/ws. rise = sck_s & ~sck_d. With SYNC_STAGES=2, clk_en rises 3 clk cycles after an sck_in rising edge meeting setup.
- All outputs are registered. sd is the synced SD value sampled in the rise cycle.
- WS is sampled only on rise cycles. A WS transition is a sampled ws differing from the previously sampled ws.
- eff_res = resolution if 16 <= resolution <= 32, else 16. Latched on each WS transition; mid-word changes have no effect on the current word.
- States:
  - IDLE: outputs quiet. Go to SYNC when rx_en=1.
  - SYNC: wait for a sampled WS 1->0 transition, i.e. start of the left channel. Then go to ACTIVE with bit_cnt=0.
  - ACTIVE: on each rise, bit_cnt increments (saturating). On a WS transition, bit_cnt resets to 0.
    - Position 0 after a transition is the Philips delay bit: clk_en stays low.
    - Positions 1..eff_res: clk_en=1, ws = channel.
    - Positions > eff_res, i.e. slot padding: clk_en stays low.
    - word_done pulses at position eff_res.
    - frame_start pulses at position 1 of the left channel.
- Short word: a WS transition while the current word has fewer than eff_res bits delivered, and at least one delivered, sets frame_err and sends the FSM to SYNC. No clk_en is issued for the truncated remainder. A WS transition at position 0 also counts as a short word.
- frame_err is cleared by err_clr. If set and clear occur in the same cycle, set wins.
- rx_en=0 in any state: next cycle go to IDLE. clk_en, frame_start, word_done, locked and bit_cnt go to 0; frame_err is retained.
- Re-enable always passes through SYNC, so no partial word is ever emitted.
- Reset asserted mid-word: immediate return to reset values; no further strobes.

Test Plan:
- resolution=16, 16-bit slots, L=0xA5C3, R=0x3C5A, clk=8x SCK -> 32 clk_en strobes per frame in MSB-first order matching the words; frame_start once; word_done twice; frame_err=0.
- resolution=24, 32-bit slots -> exactly 24 strobes per channel; bits 25..31 are padding with no strobe; bit_cnt reaches 31 before reset to 0.
- resolution=40 (illegal) -> behaves as 16: 16 strobes per channel.
- resolution=24, WS toggles after 10 data bits -> frame_err=1; locked drops; no strobes until the next WS 1->0; then normal capture resumes.
- rx_en dropped at bit 7 of the left word, then raised mid-right word -> no strobes until the next left word starts; frame_err remains 0.
- frame_err=1, then err_clr pulse in the same cycle as a new short-word event -> frame_err stays 1; a later isolated err_clr pulse clears it to 0.

Source files
------------

// File: rtl/ai_i2s_rx_frontend.sv
// I2S receive front end: brings slave-mode SCK/WS/SD into the system clock
// domain, tracks Philips-I2S frame alignment and hands the downstream
// deserializer a one-cycle clk_en strobe with a registered data bit for
// every data bit of each channel word. Short words raise a sticky error.
module ai_i2s_rx_frontend #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_en,
    input  logic [5:0]           resolution,
    input  logic                 err_clr,
    input  logic                 sck_in,
    input  logic                 ws_in,
    input  logic                 sd_in,
    output logic                 clk_en,
    output logic                 sd,
    output logic                 ws,
    output logic                 frame_start,
    output logic                 word_done,
    output logic [CNT_WIDTH-1:0] bit_cnt,
    output logic                 frame_err,
    output logic                 locked
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [5:0]           RES_DEFAULT = 6'd16;

    // Synchronizer chains and edge-detect history
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] ws_sync_q, ws_sync_d;
    logic [SYNC_STAGES-1:0] sd_sync_q, sd_sync_d;
    logic                   sck_hist_q, sck_hist_d;
    logic                   ws_hist_q, ws_hist_d;

    // Framing state
    logic [1:0]             state_q, state_d;
    logic [5:0]             eff_res_q, eff_res_d;
    logic [CNT_WIDTH-1:0]   bit_cnt_q, bit_cnt_d;

    // Registered outputs
    logic                   clk_en_q, clk_en_d;
    logic                   sd_q, sd_d;
    logic                   ws_q, ws_d;
    logic                   frame_start_q, frame_start_d;
    logic                   word_done_q, word_done_d;
    logic                   frame_err_q, frame_err_d;
    logic                   locked_q, locked_d;

    // Combinational helpers
    logic                   sck_s, ws_s, sd_s;
    logic                   rise, ws_trans;
    logic [5:0]             res_legal;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic [31:0]            cur_ext, inc_ext, eff_ext;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign ws_s     = ws_sync_q[SYNC_STAGES-1];
    assign sd_s     = sd_sync_q[SYNC_STAGES-1];
    assign rise     = sck_s & ~sck_hist_q;
    assign ws_trans = rise & (ws_s != ws_hist_q);

    assign res_legal = ((resolution >= 6'd16) && (resolution <= 6'd32)) ? resolution : RES_DEFAULT;
    assign cnt_inc   = (bit_cnt_q == CNT_MAX) ? bit_cnt_q : bit_cnt_q + CNT_ONE;
    assign cur_ext   = 32'(bit_cnt_q);
    assign inc_ext   = 32'(cnt_inc);
    assign eff_ext   = 32'(eff_res_q);

    // Next-state logic: sampling on SCK rises, framing FSM, strobe generation
    always_comb begin
        sck_sync_d    = {sck_sync_q[SYNC_STAGES-2:0], sck_in};
        ws_sync_d     = {ws_sync_q[SYNC_STAGES-2:0], ws_in};
        sd_sync_d     = {sd_sync_q[SYNC_STAGES-2:0], sd_in};
        sck_hist_d    = sck_s;
        ws_hist_d     = ws_hist_q;
        eff_res_d     = eff_res_q;
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        clk_en_d      = 1'b0;
        frame_start_d = 1'b0;
        word_done_d   = 1'b0;
        sd_d          = sd_q;
        ws_d          = ws_q;
        frame_err_d   = frame_err_q & ~err_clr;

        // WS history and the word length follow the line in every state so
        // that a later lock-on starts from a correct view of the channel.
        if (rise) begin
            ws_hist_d = ws_s;
            if (ws_trans) begin
                eff_res_d = res_legal;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_en) begin
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                bit_cnt_d = '0;
                if (ws_trans && !ws_s) begin
                    state_d = ST_ACTIVE;
                    ws_d    = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (rise) begin
                    sd_d = sd_s;
                    ws_d = ws_s;
                    if (ws_trans) begin
                        bit_cnt_d = '0;
                        // The word ending here (old eff_res) must be complete.
                        if (cur_ext < eff_ext) begin
                            frame_err_d = 1'b1;
                            state_d     = ST_SYNC;
                        end
                    end else begin
                        bit_cnt_d = cnt_inc;
                        if ((inc_ext >= 32'd1) && (inc_ext <= eff_ext)) begin
                            clk_en_d      = 1'b1;
                            frame_start_d = (inc_ext == 32'd1) && !ws_s;
                            word_done_d   = (inc_ext == eff_ext);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!rx_en) begin
            state_d       = ST_IDLE;
            bit_cnt_d     = '0;
            clk_en_d      = 1'b0;
            frame_start_d = 1'b0;
            word_done_d   = 1'b0;
        end

        locked_d = (state_d == ST_ACTIVE);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_q    <= '0;
            ws_sync_q     <= '0;
            sd_sync_q     <= '0;
            sck_hist_q    <= 1'b0;
            ws_hist_q     <= 1'b0;
            state_q       <= ST_IDLE;
            eff_res_q     <= RES_DEFAULT;
            bit_cnt_q     <= '0;
            clk_en_q      <= 1'b0;
            sd_q          <= 1'b0;
            ws_q          <= 1'b0;
            frame_start_q <= 1'b0;
            word_done_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            sck_sync_q    <= sck_sync_d;
            ws_sync_q     <= ws_sync_d;
            sd_sync_q     <= sd_sync_d;
            sck_hist_q    <= sck_hist_d;
            ws_hist_q     <= ws_hist_d;
            state_q       <= state_d;
            eff_res_q     <= eff_res_d;
            bit_cnt_q     <= bit_cnt_d;
            clk_en_q      <= clk_en_d;
            sd_q          <= sd_d;
            ws_q          <= ws_d;
            frame_start_q <= frame_start_d;
            word_done_q   <= word_done_d;
            frame_err_q   <= frame_err_d;
            locked_q      <= locked_d;
        end
    end

    assign clk_en      = clk_en_q;
    assign sd          = sd_q;
    assign ws          = ws_q;
    assign frame_start = frame_start_q;
    assign word_done   = word_done_q;
    assign bit_cnt     = bit_cnt_q;
    assign frame_err   = frame_err_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_ai_i2s_rx_frontend.sv
// Testbench for ai_i2s_rx_frontend: drives I2S bit streams at SCK = clk/8,
// records every clk_en strobe and compares against a word-level model of
// Philips-I2S framing built from the same bit stream.
module tb_ai_i2s_rx_frontend;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_en = 1'b0;
    logic [5:0] resolution = 6'd16;
    logic       err_clr = 1'b0;
    logic       sck_in = 1'b0;
    logic       ws_in = 1'b1;
    logic       sd_in = 1'b0;
    logic       clk_en, sd, ws, frame_start, word_done, frame_err, locked;
    logic [5:0] bit_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Stimulus: one entry per SCK bit
    logic seq_ws[$];
    logic seq_sd[$];
    logic seq_en[$];
    logic seq_clr[$];

    // Observed and expected strobes, packed {ws, sd, frame_start, word_done}
    logic [3:0] obs[$];
    logic [3:0] expq[$];
    int         max_cnt = 0;
    logic       mon_clear = 1'b0;
    logic       exp_err;
    logic       exp_locked;

    always #5 clk = ~clk;

    ai_i2s_rx_frontend #(.SYNC_STAGES(2), .CNT_WIDTH(6)) dut (
        .clk(clk), .rst(rst), .rx_en(rx_en), .resolution(resolution),
        .err_clr(err_clr), .sck_in(sck_in), .ws_in(ws_in), .sd_in(sd_in),
        .clk_en(clk_en), .sd(sd), .ws(ws), .frame_start(frame_start),
        .word_done(word_done), .bit_cnt(bit_cnt), .frame_err(frame_err),
        .locked(locked)
    );

    // Strobe monitor, sampling 2 ns after each rising clock edge
    always @(posedge clk) begin
        #2;
        if (mon_clear) begin
            obs.delete();
            max_cnt = 0;
        end else begin
            if (clk_en) obs.push_back({ws, sd, frame_start, word_done});
            if (int'(bit_cnt) > max_cnt) max_cnt = int'(bit_cnt);
        end
    end

    function automatic void add_bit(input logic w, input logic s);
        seq_ws.push_back(w);
        seq_sd.push_back(s);
        seq_en.push_back(1'b1);
        seq_clr.push_back(1'b0);
    endfunction

    // One channel slot: delay bit, nbits data bits MSB first, random padding
    function automatic void add_slot(input logic w, input logic [31:0] data, input int nbits, input int slot_len);
        for (int p = 0; p < slot_len; p++) begin
            if (p >= 1 && p <= nbits) add_bit(w, data[nbits-p]);
            else add_bit(w, 1'($urandom_range(0, 1)));
        end
    endfunction

    task automatic do_reset(input logic [5:0] res);
        @(negedge clk);
        rst = 1'b1; rx_en = 1'b0; err_clr = 1'b0; sck_in = 1'b0;
        ws_in = 1'b1; sd_in = 1'b0; resolution = res; mon_clear = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0; mon_clear = 1'b0;
        seq_ws.delete(); seq_sd.delete(); seq_en.delete(); seq_clr.delete();
        @(negedge clk);
    endtask

    // Each bit: SCK low 4 clocks (WS/SD/rx_en change here), then high 4 clocks.
    // An err_clr request lands on the clock edge that registers this rise.
    task automatic drive_bits(input int from, input int to);
        for (int i = from; i < to; i++) begin
            @(negedge clk);
            sck_in = 1'b0; ws_in = seq_ws[i]; sd_in = seq_sd[i]; rx_en = seq_en[i];
            repeat (3) @(negedge clk);
            @(negedge clk); sck_in = 1'b1;
            @(negedge clk);
            @(negedge clk); if (seq_clr[i]) err_clr = 1'b1;
            @(negedge clk); err_clr = 1'b0;
        end
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    // Reference model: walks the bit stream word by word
    task automatic build_expected(input int res);
        int   eff, cur_eff, pos;
        logic hunting, capturing, prev, w;
        eff = (res >= 16 && res <= 32) ? res : 16;
        cur_eff = 16; pos = 0; hunting = 0; capturing = 0; prev = 0;
        exp_err = 0; expq.delete();
        for (int i = 0; i < seq_ws.size(); i++) begin
            w = seq_ws[i];
            if (!seq_en[i]) begin
                hunting = 0; capturing = 0; pos = 0;
            end else begin
                if (!hunting && !capturing) hunting = 1;
                if (w != prev) begin
                    if (capturing && pos < cur_eff) begin
                        exp_err = 1; capturing = 0; hunting = 1;
                    end else if (hunting && w == 1'b0) begin
                        hunting = 0; capturing = 1;
                    end
                    pos = 0;
                end else if (capturing) begin
                    if (pos < 63) pos++;
                    if (pos >= 1 && pos <= cur_eff)
                        expq.push_back({w, seq_sd[i], (pos == 1 && w == 1'b0), (pos == cur_eff)});
                end
            end
            if (w != prev) cur_eff = eff;
            prev = w;
        end
        exp_locked = capturing;
    endtask

    function automatic int first_diff();
        int n = (obs.size() < expq.size()) ? obs.size() : expq.size();
        for (int i = 0; i < n; i++) if (obs[i] !== expq[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        n_cmp++;
        if ({clk_en, sd, ws, frame_start, word_done} !== 5'b0) begin
            n_bad++; $display("[TB] FAIL reset_strobes: got %b expected 00000", {clk_en, sd, ws, frame_start, word_done});
        end
        n_cmp++;
        if ({bit_cnt, frame_err, locked} !== 8'b0) begin
            n_bad++; $display("[TB] FAIL reset_state: got %b expected 0", {bit_cnt, frame_err, locked});
        end
        // Reset asserted in the middle of a left word
        do_reset(6'd16);
        add_slot(1'b1, 32'h0, 0, 3);
        add_slot(1'b0, 32'h1234, 16, 17);
        drive_bits(0, 9);
        settle();
        n_cmp++;
        if (obs.size() != 5 || bit_cnt !== 6'd5 || locked !== 1'b1) begin
            n_bad++; $display("[TB] FAIL midword_pre: got strobes=%0d cnt=%0d locked=%b expected 5 5 1", obs.size(), bit_cnt, locked);
        end
        @(negedge clk); rst = 1'b1; #1;
        n_cmp++;
        if ({clk_en, bit_cnt, locked, frame_start, word_done} !== 10'b0) begin
            n_bad++; $display("[TB] FAIL midword_reset: got %b expected 0", {clk_en, bit_cnt, locked, frame_start, word_done});
        end
        drive_bits(9, seq_ws.size());
        settle();
        n_cmp++;
        if (obs.size() != 5) begin
            n_bad++; $display("[TB] FAIL midword_quiet: got %0d strobes expected 5", obs.size());
        end
        rst = 1'b0;
    endtask

    task automatic test_res16();
        logic [15:0] lw, rw;
        int fs, wd, d;
        do_reset(6'd16);
        add_slot(1'b1, 32'h0, 0, 3);
        // Each half carries the Philips delay bit plus 16 data bits
        add_slot(1'b0, 32'hA5C3, 16, 17);
        add_slot(1'b1, 32'h3C5A, 16, 17);
        drive_bits(0, seq_ws.size());
        settle();
        build_expected(16);
        lw = '0; rw = '0; fs = 0; wd = 0;
        for (int i = 0; i < 16; i++) begin
            if (i < obs.size()) lw = {lw[14:0], obs[i][2]};
            if (16 + i < obs.size()) rw = {rw[14:0], obs[16+i][2]};
        end
        foreach (obs[i]) begin fs += int'(obs[i][1]); wd += int'(obs[i][0]); end
        n_cmp++;
        if (obs.size() != 32) begin n_bad++; $display("[TB] FAIL res16_count: got %0d expected 32", obs.size()); end
        n_cmp++;
        if (lw !== 16'hA5C3) begin n_bad++; $display("[TB] FAIL res16_left: got %h expected a5c3", lw); end
        n_cmp++;
        if (rw !== 16'h3C5A) begin n_bad++; $display("[TB] FAIL res16_right: got %h expected 3c5a", rw); end
        n_cmp++;
        if (fs != 1 || wd != 2) begin n_bad++; $display("[TB] FAIL res16_pulses: got fs=%0d wd=%0d expected 1 2", fs, wd); end
        n_cmp++;
        if (frame_err !== 1'b0) begin n_bad++; $display("[TB] FAIL res16_err: got %b expected 0", frame_err); end
        d = first_diff();
        n_cmp++;
        if (d >= 0 || obs.size() != expq.size()) begin
            n_bad++; $display("[TB] FAIL res16_model: idx=%0d got %b expected %b", d, (d >= 0) ? obs[d] : 4'b0, (d >= 0) ? expq[d] : 4'b0);
        end
    endtask

    task automatic test_res24_padding();
        int d;
        do_reset(6'd24);
        add_slot(1'b1, 32'h0, 0, 3);
        for (int f = 0; f < 2; f++) begin
            add_slot(1'b0, 32'($urandom), 24, 32);
            add_slot(1'b1, 32'($urandom), 24, 32);
        end
        drive_bits(0, seq_ws.size());
        settle();
        build_expected(24);
        n_cmp++;
        if (obs.size() != 96) begin n_bad++; $display("[TB] FAIL res24_count: got %0d expected 96", obs.size()); end
        n_cmp++;
        if (max_cnt != 31) begin n_bad++; $display("[TB] FAIL res24_maxcnt: got %0d expected 31", max_cnt); end
        n_cmp++;
        if (frame_err !== 1'b0 || locked !== 1'b1) begin
            n_bad++; $display("[TB] FAIL res24_flags: got err=%b locked=%b expected 0 1", frame_err, locked);
        end
        d = first_diff();
        n_cmp++;
        if (d >= 0 || obs.size() != expq.size()) begin
            n_bad++; $display("[TB] FAIL res24_model: idx=%0d got %b expected %b", d, (d >= 0) ? obs[d] : 4'b0, (d >= 0) ? expq[d] : 4'b0);
        end
    endtask

    task automatic test_illegal_res();
        logic [5:0] bad_res[2] = '{6'd40, 6'd9};
        int d;
        for (int k = 0; k < 2; k++) begin
            do_reset(bad_res[k]);
            add_slot(1'b1, 32'h0, 0, 3);
            for (int f = 0; f < 2; f++) begin
                add_slot(1'b0, 32'($urandom), 16, 20);
                add_slot(1'b1, 32'($urandom), 16, 20);
            end
            drive_bits(0, seq_ws.size());
            settle();
            build_expected(int'(bad_res[k]));
            n_cmp++;
            if (obs.size() != 64 || frame_err !== 1'b0) begin
                n_bad++; $display("[TB] FAIL illegal_res_%0d: got %0d strobes err=%b expected 64 0", bad_res[k], obs.size(), frame_err);
            end
            d = first_diff();
            n_cmp++;
            if (d >= 0 || obs.size() != expq.size()) begin
                n_bad++; $display("[TB] FAIL illegal_res_model: idx=%0d got %b expected %b", d, (d >= 0) ? obs[d] : 4'b0, (d >= 0) ? expq[d] : 4'b0);
            end
        end
    endtask

    task automatic test_short_word();
        int d, cut;
        do_reset(6'd24);
        add_slot(1'b1, 32'h0, 0, 3);
        add_slot(1'b0, 32'($urandom), 24, 32);
        add_slot(1'b1, 32'($urandom), 24, 32);
        add_slot(1'b0, 32'($urandom), 10, 11);
        cut = seq_ws.size() + 3;
        add_slot(1'b1, 32'($urandom), 24, 32);
        add_slot(1'b0, 32'($urandom), 24, 32);
        add_slot(1'b1, 32'($urandom), 24, 32);
        drive_bits(0, cut);
        settle();
        n_cmp++;
        if (frame_err !== 1'b1 || locked !== 1'b0 || obs.size() != 58) begin
            n_bad++; $display("[TB] FAIL short_detect: got err=%b locked=%b strobes=%0d expected 1 0 58", frame_err, locked, obs.size());
        end
        drive_bits(cut, seq_ws.size());
        settle();
        build_expected(24);
        n_cmp++;
        if (obs.size() != 106 || locked !== 1'b1) begin
            n_bad++; $display("[TB] FAIL short_resume: got strobes=%0d locked=%b expected 106 1", obs.size(), locked);
        end
        d = first_diff();
        n_cmp++;
        if (d >= 0 || obs.size() != expq.size() || frame_err !== exp_err) begin
            n_bad++; $display("[TB] FAIL short_model: idx=%0d got %b expected %b", d, (d >= 0) ? obs[d] : 4'b0, (d >= 0) ? expq[d] : 4'b0);
        end
    endtask

    task automatic test_rx_en_drop();
        int d;
        do_reset(6'd16);
        add_slot(1'b1, 32'h0, 0, 3);
        for (int f = 0; f < 2; f++) begin
            add_slot(1'b0, 32'($urandom), 16, 17);
            add_slot(1'b1, 32'($urandom), 16, 17);
        end
        // Off from left position 8 until right position 8
        for (int i = 11; i < 28; i++) seq_en[i] = 1'b0;
        drive_bits(0, 16);
        settle();
        n_cmp++;
        if (locked !== 1'b0 || obs.size() != 7 || bit_cnt !== 6'd0) begin
            n_bad++; $display("[TB] FAIL rxen_off: got locked=%b strobes=%0d cnt=%0d expected 0 7 0", locked, obs.size(), bit_cnt);
        end
        drive_bits(16, seq_ws.size());
        settle();
        build_expected(16);
        n_cmp++;
        if (obs.size() != 39 || frame_err !== 1'b0) begin
            n_bad++; $display("[TB] FAIL rxen_resume: got strobes=%0d err=%b expected 39 0", obs.size(), frame_err);
        end
        d = first_diff();
        n_cmp++;
        if (d >= 0 || obs.size() != expq.size()) begin
            n_bad++; $display("[TB] FAIL rxen_model: idx=%0d got %b expected %b", d, (d >= 0) ? obs[d] : 4'b0, (d >= 0) ? expq[d] : 4'b0);
        end
    endtask

    task automatic test_err_clr_collision();
        int d;
        do_reset(6'd16);
        add_slot(1'b1, 32'h0, 0, 3);
        add_slot(1'b0, 32'($urandom), 5, 6);
        add_slot(1'b1, 32'($urandom), 16, 17);
        add_slot(1'b0, 32'($urandom), 16, 17);
        add_slot(1'b1, 32'($urandom), 16, 17);
        add_slot(1'b0, 32'($urandom), 4, 5);
        add_slot(1'b1, 32'($urandom), 16, 17);
        seq_clr[65] = 1'b1;
        drive_bits(0, 12);
        settle();
        n_cmp++;
        if (frame_err !== 1'b1) begin n_bad++; $display("[TB] FAIL clr_first_set: got %b expected 1", frame_err); end
        drive_bits(12, seq_ws.size());
        settle();
        n_cmp++;
        if (frame_err !== 1'b1 || locked !== 1'b0) begin
            n_bad++; $display("[TB] FAIL clr_set_wins: got err=%b locked=%b expected 1 0", frame_err, locked);
        end
        build_expected(16);
        d = first_diff();
        n_cmp++;
        if (d >= 0 || obs.size() != 41 || expq.size() != 41) begin
            n_bad++; $display("[TB] FAIL clr_model: idx=%0d strobes=%0d expected 41", d, obs.size());
        end
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (frame_err !== 1'b0) begin n_bad++; $display("[TB] FAIL clr_isolated: got %b expected 0", frame_err); end
    endtask

    task automatic test_back_to_back();
        int d, res, eff, nb, sl;
        for (int run = 0; run < 3; run++) begin
            res = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(16, 32);
            eff = (res >= 16 && res <= 32) ? res : 16;
            do_reset(6'(res));
            add_slot(1'b1, 32'h0, 0, 3);
            for (int s = 0; s < 6; s++) begin
                if ($urandom_range(0, 4) == 0) begin
                    nb = $urandom_range(0, eff - 1); sl = nb + 1;
                end else begin
                    nb = eff; sl = $urandom_range(eff + 1, 36);
                end
                add_slot(1'(s % 2), 32'($urandom), nb, sl);
            end
            drive_bits(0, seq_ws.size());
            settle();
            build_expected(res);
            n_cmp++;
            if (obs.size() != expq.size()) begin
                n_bad++; $display("[TB] FAIL b2b_count res=%0d: got %0d expected %0d", res, obs.size(), expq.size());
            end
            d = first_diff();
            n_cmp++;
            if (d >= 0) begin
                n_bad++; $display("[TB] FAIL b2b_data res=%0d idx=%0d: got %b expected %b", res, d, obs[d], expq[d]);
            end
            n_cmp++;
            if (frame_err !== exp_err || locked !== exp_locked) begin
                n_bad++; $display("[TB] FAIL b2b_flags res=%0d: got err=%b locked=%b expected %b %b", res, frame_err, locked, exp_err, exp_locked);
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_res16();
        test_res24_padding();
        test_illegal_res();
        test_short_word();
        test_rx_en_drop();
        test_err_clr_collision();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
